// File: rtl/vga_sprite_engine_pkg.sv
// Shared VGA types and 640x480@60 timing constants for the sprite engine.
package vga_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  localparam int H_ACTIVE_640 = 640;
  localparam int H_FP_640     = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;
  localparam int V_ACTIVE_480 = 480;
  localparam int V_FP_480     = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BP_480     = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_sprite_engine_timing.sv
// Pixel-tick divider, raster counters and registered sync generation.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = H_ACTIVE_640,
  parameter int   H_FP     = H_FP_640,
  parameter int   H_SYNC   = H_SYNC_640,
  parameter int   H_BP     = H_BP_640,
  parameter int   V_ACTIVE = V_ACTIVE_480,
  parameter int   V_FP     = V_FP_480,
  parameter int   V_SYNC   = V_SYNC_480,
  parameter int   V_BP     = V_BP_480,
  parameter logic HS_POL   = SYNC_ACTIVE_LOW,
  parameter logic VS_POL   = SYNC_ACTIVE_LOW,
  parameter int   CW       = 10
) (
  input  logic          clock,
  input  logic          reset,
  output logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div    <= '0;
      pix_en <= 1'b0;
      hcount <= '0;
      vcount <= '0;
      hsync  <= ~HS_POL;
      vsync  <= ~VS_POL;
    end else begin
      pix_en <= (div == DIV_LAST);
      div    <= (div == DIV_LAST) ? '0 : div + DW'(1);
      if (pix_en) begin
        // Syncs use the pre-increment counts so they stay aligned with rgb.
        hsync <= (hcount >= HS_START && hcount < HS_END) ? HS_POL : ~HS_POL;
        vsync <= (vcount >= VS_START && vcount < VS_END) ? VS_POL : ~VS_POL;
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + CW'(1);
        end else begin
          hcount <= hcount + CW'(1);
        end
      end
    end
  end

  assign frame_start = pix_en && (hcount == '0) && (vcount == '0);

endmodule

// File: rtl/vga_sprite_engine.sv
// VGA timing plus N-channel rectangular sprite compositor with vblank-committed
// double-buffered sprite registers.
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int      CLK_DIV  = 4,
  parameter int      H_ACTIVE = H_ACTIVE_640,
  parameter int      H_FP     = H_FP_640,
  parameter int      H_SYNC   = H_SYNC_640,
  parameter int      H_BP     = H_BP_640,
  parameter int      V_ACTIVE = V_ACTIVE_480,
  parameter int      V_FP     = V_FP_480,
  parameter int      V_SYNC   = V_SYNC_480,
  parameter int      V_BP     = V_BP_480,
  parameter logic    HS_POL   = SYNC_ACTIVE_LOW,
  parameter logic    VS_POL   = SYNC_ACTIVE_LOW,
  parameter int      CW       = 10,
  parameter int      N_SPR    = 4,
  parameter int      SPR_W    = 16,
  parameter int      SPR_H    = 16,
  parameter rgb332_t BG_COLOR = 8'h00,
  localparam int     SW       = (N_SPR > 1) ? $clog2(N_SPR) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [SW-1:0] wr_sel,
  input  logic [CW-1:0] wr_x,
  input  logic [CW-1:0] wr_y,
  input  logic [7:0]    wr_color,
  input  logic          wr_on,
  output logic [2:0]    red,
  output logic [2:0]    green,
  output logic [1:0]    blue,
  output logic          hsync,
  output logic          vsync,
  output logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          frame_start
);

  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW:0]   SPR_W_E  = (CW+1)'(SPR_W);
  localparam logic [CW:0]   SPR_H_E  = (CW+1)'(SPR_H);

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL  (HS_POL),   .VS_POL(VS_POL),
    .CW      (CW)
  ) u_timing (
    .clock      (clock),
    .reset      (reset),
    .pix_en     (pix_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start),
    .hcount     (hcount),
    .vcount     (vcount)
  );

  logic [CW-1:0]    sh_x [N_SPR];
  logic [CW-1:0]    sh_y [N_SPR];
  rgb332_t          sh_c [N_SPR];
  logic [N_SPR-1:0] sh_on;
  logic [CW-1:0]    lv_x [N_SPR];
  logic [CW-1:0]    lv_y [N_SPR];
  rgb332_t          lv_c [N_SPR];
  logic [N_SPR-1:0] lv_on;
  logic             ready_q;
  logic             commit;
  rgb332_t          pix_c;
  rgb332_t          rgb_q;
  logic             found;
  logic [CW:0]      hx;
  logic [CW:0]      vy;

  assign commit   = pix_en && (hcount == '0) && (vcount == V_ACT_C);
  assign wr_ready = ready_q && !commit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      sh_on   <= '0;
      lv_on   <= '0;
      for (int unsigned i = 0; i < N_SPR; i++) begin
        sh_x[i] <= '0;
        sh_y[i] <= '0;
        sh_c[i] <= '0;
        lv_x[i] <= '0;
        lv_y[i] <= '0;
        lv_c[i] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      if (commit) begin
        lv_on <= sh_on;
        for (int unsigned i = 0; i < N_SPR; i++) begin
          lv_x[i] <= sh_x[i];
          lv_y[i] <= sh_y[i];
          lv_c[i] <= sh_c[i];
        end
      end
      // Out-of-range indices match no channel and are silently dropped.
      if (wr_valid && wr_ready) begin
        for (int unsigned i = 0; i < N_SPR; i++) begin
          if (wr_sel == SW'(i)) begin
            sh_x[i]  <= wr_x;
            sh_y[i]  <= wr_y;
            sh_c[i]  <= rgb332_t'(wr_color);
            sh_on[i] <= wr_on;
          end
        end
      end
    end
  end

  // Extended-width compare keeps sprites from wrapping past the counter range.
  always_comb begin
    hx    = {1'b0, hcount};
    vy    = {1'b0, vcount};
    pix_c = BG_COLOR;
    found = 1'b0;
    for (int unsigned i = 0; i < N_SPR; i++) begin
      if (!found && lv_on[i] &&
          hx >= {1'b0, lv_x[i]} && hx < {1'b0, lv_x[i]} + SPR_W_E &&
          vy >= {1'b0, lv_y[i]} && vy < {1'b0, lv_y[i]} + SPR_H_E) begin
        pix_c = lv_c[i];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
    end else if (pix_en) begin
      rgb_q <= (hcount >= H_ACT_C || vcount >= V_ACT_C) ? rgb332_t'('0) : pix_c;
    end
  end

  assign red   = rgb_q.r;
  assign green = rgb_q.g;
  assign blue  = rgb_q.b;

endmodule
